// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: access modes, FSM states,
// and load-result extension.
package mem_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Select the addressed byte/half of a word and extend it to 32 bits
    // according to the funct3 access mode. Unknown modes return zero.
    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [2:0]  mode,
                                             input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (mode)
            MEM_B:   r = {{24{b[7]}}, b};
            MEM_H:   r = {{16{h[15]}}, h};
            MEM_W:   r = word;
            MEM_BU:  r = {24'd0, b};
            MEM_HU:  r = {16'd0, h};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
interface dmem_responder_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_acc_mode;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_acc_mode, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_acc_mode, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bank.sv
// Word-organised storage: synchronous byte-enabled write, combinational read.
// Contents are deliberately not reset.
module dmem_bank #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);
    logic [31:0] mem [DEPTH];

    // Write only the enabled byte lanes of the addressed word.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed number
// of cycles, then presents a registered response until the core takes it.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    dmem_responder_if.slave    bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_t            state, next_state;
    logic [3:0]        cnt, cnt_next;
    logic              accept;
    logic              enter_resp;

    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [2:0]        l_mode;
    logic [31:0]       l_wdata;

    logic [IDX_W-1:0]  idx;
    logic [31:0]       bank_rdata;
    logic              bank_we;
    logic [3:0]        st_be;
    logic [31:0]       st_data;

    logic              illegal;
    logic              misalign;
    logic              oor;
    logic              err_next;
    logic [31:0]       rdata_next;

    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    // State and wait counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Every accept passes through WAIT (counter preloaded with WAIT_CYCLES), so the
    // response appears 1+WAIT_CYCLES edges after accept even when WAIT_CYCLES is 0.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    next_state = WAIT;
                    cnt_next   = 4'(WAIT_CYCLES);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    next_state = RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign enter_resp = (state == WAIT) && (cnt == '0);

    // Capture the request fields at the accepting edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l_we    <= 1'b0;
            l_addr  <= '0;
            l_mode  <= '0;
            l_wdata <= '0;
        end else if (accept) begin
            l_we    <= bus.req_we;
            l_addr  <= bus.req_addr;
            l_mode  <= bus.req_acc_mode;
            l_wdata <= bus.req_wdata;
        end
    end

    assign idx = l_addr[IDX_W+1:2];

    if (ADDR_W > IDX_W + 2) begin : g_range
        assign oor = |l_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_range
        assign oor = 1'b0;
    end

    // Classify the latched request and form load result and store lanes.
    always_comb begin
        illegal    = 1'b0;
        st_be      = '0;
        st_data    = '0;
        case (l_mode)
            MEM_B: begin
                st_be   = 4'b0001 << l_addr[1:0];
                st_data = {4{l_wdata[7:0]}};
            end
            MEM_H: begin
                st_be   = l_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{l_wdata[15:0]}};
            end
            MEM_W: begin
                st_be   = 4'b1111;
                st_data = l_wdata;
            end
            MEM_BU, MEM_HU: illegal = l_we;
            default:        illegal = 1'b1;
        endcase
        misalign   = ((l_mode[1:0] == 2'b01) && l_addr[0]) ||
                     ((l_mode == MEM_W) && (l_addr[1:0] != 2'b00));
        err_next   = illegal || misalign || oor;
        rdata_next = (err_next || l_we) ? '0 : load_ext(bank_rdata, l_mode, l_addr[1:0]);
    end

    assign bank_we = enter_resp && l_we && !err_next;

    dmem_bank #(
        .DEPTH (DEPTH)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .be    (st_be),
        .idx   (idx),
        .wdata (st_data),
        .rdata (bank_rdata)
    );

    // Register the response on entry to RESP and hold it until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (enter_resp) begin
            rsp_rdata_q <= rdata_next;
            rsp_err_q   <= err_next;
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder (DEPTH=256, WAIT_CYCLES=3).
module tb_dmem_responder;
    import mem_pkg::*;

    localparam int unsigned DEPTH       = 256;
    localparam int unsigned WAIT_CYCLES = 3;
    localparam int unsigned ADDR_W      = 32;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    exp_t sb_q[$];

    dmem_responder_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one transaction, check latency and busy behaviour, then compare the
    // response against the scoreboard entry pushed here. 'hold' keeps rsp_ready
    // low that many extra cycles while pulsing a competing store request.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [2:0] mode, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int hold);
        exp_t e;
        exp_t got;
        int   lat;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        @(negedge clk);
        check({tag, "_ready_idle"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_acc_mode = mode;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check({tag, "_ready_busy"}, 32'(bus.req_ready), 32'd0);
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.rsp_valid !== 1'b1) check({tag, "_ready_wait"}, 32'(bus.req_ready), 32'd0);
        end
        check({tag, "_latency"}, 32'(lat), 32'(1 + WAIT_CYCLES));
        check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            got = sb_q.pop_front();
            check({tag, "_rdata"}, bus.rsp_rdata, got.rdata);
            check({tag, "_err"}, 32'(bus.rsp_err), 32'(got.err));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                bus.req_valid    = (i % 2 == 0);
                bus.req_we       = 1'b1;
                bus.req_addr     = addr;
                bus.req_acc_mode = MEM_W;
                bus.req_wdata    = 32'h0;
                @(posedge clk);
                #1;
                check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
                check({tag, "_hold_rdata"}, bus.rsp_rdata, got.rdata);
                check({tag, "_hold_err"}, 32'(bus.rsp_err), 32'(got.err));
                check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
            end
            bus.req_valid = 1'b0;
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_done_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        n_assert         = 0;
        n_fail           = 0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = '0;
        bus.req_acc_mode = '0;
        bus.req_wdata    = '0;
        bus.rsp_ready    = 1'b0;
        rst_n            = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_req("sw10",   1'b1, 32'h10, MEM_W,  32'hDEADBEEF, 32'h0,        1'b0, 0);
        do_req("lw10",   1'b0, 32'h10, MEM_W,  32'h0,        32'hDEADBEEF, 1'b0, 0);
        do_req("sb11",   1'b1, 32'h11, MEM_B,  32'h000000F0, 32'h0,        1'b0, 0);
        do_req("lb11",   1'b0, 32'h11, MEM_B,  32'h0,        32'hFFFFFFF0, 1'b0, 0);
        do_req("lbu11",  1'b0, 32'h11, MEM_BU, 32'h0,        32'h000000F0, 1'b0, 0);
        do_req("lw10b",  1'b0, 32'h10, MEM_W,  32'h0,        32'hDEADF0EF, 1'b0, 0);
        do_req("lh13",   1'b0, 32'h13, MEM_H,  32'h0,        32'h0,        1'b1, 0);
        do_req("lw12",   1'b0, 32'h12, MEM_W,  32'h0,        32'h0,        1'b1, 0);
        do_req("sh11",   1'b1, 32'h11, MEM_H,  32'h0000AAAA, 32'h0,        1'b1, 0);
        do_req("lw10c",  1'b0, 32'h10, MEM_W,  32'h0,        32'hDEADF0EF, 1'b0, 0);
        do_req("lh12",   1'b0, 32'h12, MEM_H,  32'h0,        32'hFFFFDEAD, 1'b0, 0);
        do_req("lhu10",  1'b0, 32'h10, MEM_HU, 32'h0,        32'h0000F0EF, 1'b0, 0);

        // Out-of-range store would alias word 0 if the range check were missing.
        do_req("sw00",   1'b1, 32'h0,   MEM_W,  32'h11111111, 32'h0,        1'b0, 0);
        do_req("sw_oor", 1'b1, 32'h400, MEM_W,  32'h22222222, 32'h0,        1'b1, 0);
        do_req("lw_oor", 1'b0, 32'h400, MEM_W,  32'h0,        32'h0,        1'b1, 0);
        do_req("sm011",  1'b1, 32'h0,   3'b011, 32'h33333333, 32'h0,        1'b1, 0);
        do_req("sbu00",  1'b1, 32'h0,   MEM_BU, 32'h44444444, 32'h0,        1'b1, 0);
        do_req("lm110",  1'b0, 32'h0,   3'b110, 32'h0,        32'h0,        1'b1, 0);
        do_req("lw00",   1'b0, 32'h0,   MEM_W,  32'h0,        32'h11111111, 1'b0, 0);

        // Held response with competing store pulses that must be ignored.
        do_req("hold",   1'b0, 32'h10, MEM_W,  32'h0,        32'hDEADF0EF, 1'b0, 5);
        do_req("lw10d",  1'b0, 32'h10, MEM_W,  32'h0,        32'hDEADF0EF, 1'b0, 0);

        // Reset during WAIT aborts the store without touching the array.
        do_req("sw20",   1'b1, 32'h20, MEM_W,  32'hCAFEF00D, 32'h0,        1'b0, 0);
        do_req("lw20",   1'b0, 32'h20, MEM_W,  32'h0,        32'hCAFEF00D, 1'b0, 0);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_addr     = 32'h20;
        bus.req_acc_mode = MEM_W;
        bus.req_wdata    = 32'h12345678;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2;
        check("abort_in_wait", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("abort_rsp_err", 32'(bus.rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_req("lw20b",  1'b0, 32'h20, MEM_W,  32'h0,        32'hCAFEF00D, 1'b0, 0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
